// File: rtl/ebi_line_bridge.sv
// ebi_line_bridge
//   Cache-side EBI master. Requests from the L2 are queued (REQ_DEPTH entries)
//   and executed one at a time as whole-cacheline transfers over a narrow,
//   bidirectional EBI pin bus. Each transfer sends an opcode beat, the
//   address beats (LSB first) and a MESI beat. A write in M state also sends
//   the line data. The bus is then turned around and the bridge waits for a
//   response. The wait is bounded by TIMEOUT_CYCLES; on expiry an error
//   response is returned.
//
//   Optional feature macro: EBI_PARITY_EN adds even parity per EBI beat
//   (ebi_par_o / ebi_par_i). A bad received beat flags every beat of that
//   response with rerr_o.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   req_valid_i/req_ready_o      request handshake (ready = queue not full)
//   req_write_i, req_addr_i,
//   req_mesi_i                   request opcode, line address, writeback state
//   wvalid_i/wready_o/wdata_i    write line data, lowest beat first
//   rvalid_o/rready_i/rdata_o    response beats
//   rmesi_o, rlast_o, rerr_o     returned MESI state, last beat, error
//   ebi_i/ebi_o/ebi_oen          pad in/out/output-enable (0 = drive)
//   busy_o                       transfer in progress or requests queued
module ebi_line_bridge #(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned PADDR_WIDTH      = 32,
    parameter int unsigned CACHELINE_LENGTH = 512,
    parameter int unsigned EBI_WIDTH        = 16,
    parameter int unsigned REQ_DEPTH        = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [PADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]             req_mesi_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DATA_WIDTH-1:0]  rdata_o,
    output logic [1:0]             rmesi_o,
    output logic                   rlast_o,
    output logic                   rerr_o,
    input  logic [EBI_WIDTH-1:0]   ebi_i,
    output logic [EBI_WIDTH-1:0]   ebi_o,
    output logic [EBI_WIDTH-1:0]   ebi_oen,
    output logic                   busy_o
`ifdef EBI_PARITY_EN
    ,
    output logic                   ebi_par_o,
    input  logic                   ebi_par_i
`endif
);

    localparam int unsigned NA = PADDR_WIDTH / EBI_WIDTH;
    localparam int unsigned NL = CACHELINE_LENGTH / EBI_WIDTH;
    localparam int unsigned NB = CACHELINE_LENGTH / DATA_WIDTH;
    localparam int unsigned CW = $clog2(NA + NL + 2) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned QW = $clog2(REQ_DEPTH);

    localparam logic [CW-1:0] ADDR_LAST   = CW'(NA);
    localparam logic [CW-1:0] MESI_BEAT   = CW'(NA + 1);
    localparam logic [CW-1:0] DATA_FIRST  = CW'(NA + 2);
    localparam logic [CW-1:0] SEND_LAST_D = CW'(NA + 1 + NL);
    localparam logic [CW-1:0] RECV_MESI   = CW'(NL);
    localparam logic [CW-1:0] BEAT_LAST   = CW'(NB - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [QW:0]   Q_FULL      = (QW + 1)'(REQ_DEPTH);

    localparam logic [3:0] OP_DR      = 4'h0;
    localparam logic [3:0] OP_DW1     = 4'h1;
    localparam logic [3:0] OP_DW2     = 4'h2;
    localparam logic [3:0] OP_IDLE    = 4'h5;
    localparam logic [3:0] OP_RD_RESP = 4'h7;
    localparam logic [3:0] OP_ACK     = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_SEND, S_TURN, S_WAIT, S_RECV, S_RESP
    } state_t;

    state_t state, state_next;

    // request queue
    logic                   q_write [REQ_DEPTH];
    logic [PADDR_WIDTH-1:0] q_addr  [REQ_DEPTH];
    logic [1:0]             q_mesi  [REQ_DEPTH];
    logic [QW-1:0]          wr_ptr, rd_ptr;
    logic [QW:0]            q_count;
    logic                   push, pop, empty;

    // current transfer
    logic [CW-1:0]               cnt;
    logic                        cnt_inc;
    logic [TW-1:0]               timer;
    logic [CACHELINE_LENGTH-1:0] line;
    logic                        cur_write;
    logic [PADDR_WIDTH-1:0]      cur_addr;
    logic [1:0]                  cur_mesi;
    logic [3:0]                  cur_op;
    logic [1:0]                  rsp_mesi;
    logic                        err;
    logic                        par_err;
    logic                        beat_bad;
    logic                        start_beat;
    logic                        single;

    assign empty       = (q_count == '0);
    assign req_ready_o = (q_count != Q_FULL);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state == S_IDLE) && !empty;
    assign busy_o      = (state != S_IDLE) || !empty;
    assign rmesi_o     = rsp_mesi;
    assign start_beat  = (ebi_i[3:0] != OP_IDLE);
    // writes and failed transfers answer with one beat; good reads with NB
    assign single      = cur_write || err;

`ifdef EBI_PARITY_EN
    assign beat_bad  = (^ebi_i) ^ ebi_par_i;
    assign ebi_par_o = ^ebi_o;
`else
    assign beat_bad  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            q_write[wr_ptr] <= req_write_i;
            q_addr[wr_ptr]  <= req_addr_i;
            q_mesi[wr_ptr]  <= req_mesi_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + QW'(1);
            if (pop)  rd_ptr <= rd_ptr + QW'(1);
            case ({push, pop})
                2'b10:   q_count <= q_count + (QW + 1)'(1);
                2'b01:   q_count <= q_count - (QW + 1)'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_inc    = 1'b0;
        wready_o   = 1'b0;
        rvalid_o   = 1'b0;
        rlast_o    = 1'b0;
        rerr_o     = 1'b0;
        rdata_o    = '0;
        ebi_o      = '0;
        ebi_oen    = '1;
        case (state)
            S_IDLE: begin
                if (!empty)
                    state_next = (q_write[rd_ptr] && q_mesi[rd_ptr] == 2'b11) ? S_LOAD_W : S_SEND;
            end
            S_LOAD_W: begin
                wready_o = 1'b1;
                cnt_inc  = wvalid_i;
                if (wvalid_i && cnt == BEAT_LAST) state_next = S_SEND;
            end
            S_SEND: begin
                ebi_oen = '0;
                cnt_inc = 1'b1;
                if (cnt == '0)             ebi_o = EBI_WIDTH'(cur_op);
                else if (cnt <= ADDR_LAST) ebi_o = cur_addr[EBI_WIDTH-1:0];
                else if (cnt == MESI_BEAT) ebi_o = EBI_WIDTH'(cur_mesi);
                else                       ebi_o = line[EBI_WIDTH-1:0];
                if (cnt == ((cur_op == OP_DW1) ? SEND_LAST_D : MESI_BEAT))
                    state_next = S_TURN;
            end
            S_TURN: state_next = S_WAIT;
            S_WAIT: begin
                if (start_beat)
                    state_next = (!cur_write && ebi_i[3:0] == OP_RD_RESP) ? S_RECV : S_RESP;
                else if (timer == TIMER_LAST)
                    state_next = S_RESP;
            end
            S_RECV: begin
                cnt_inc = 1'b1;
                if (cnt == RECV_MESI) state_next = S_RESP;
            end
            S_RESP: begin
                rvalid_o = 1'b1;
                cnt_inc  = rready_i;
                rlast_o  = single || (cnt == BEAT_LAST);
                rerr_o   = err || par_err;
                rdata_o  = single ? '0 : line[DATA_WIDTH-1:0];
                if (rready_i && rlast_o) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The line buffer is a shift register: beats enter at the top and leave
    // from the bottom, so "lowest beat first" falls out in every direction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            timer     <= '0;
            line      <= '0;
            cur_write <= 1'b0;
            cur_addr  <= '0;
            cur_mesi  <= '0;
            cur_op    <= OP_DR;
            rsp_mesi  <= '0;
            err       <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            if (state_next != state) cnt <= '0;
            else if (cnt_inc)        cnt <= cnt + CW'(1);
            timer <= (state == S_WAIT) ? timer + TW'(1) : '0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur_write <= q_write[rd_ptr];
                        cur_addr  <= q_addr[rd_ptr];
                        cur_mesi  <= q_mesi[rd_ptr];
                        cur_op    <= !q_write[rd_ptr] ? OP_DR :
                                     (q_mesi[rd_ptr] == 2'b11) ? OP_DW1 : OP_DW2;
                        rsp_mesi  <= '0;
                        err       <= 1'b0;
                        par_err   <= 1'b0;
                    end
                end
                S_LOAD_W: begin
                    if (wvalid_i) line <= {wdata_i, line[CACHELINE_LENGTH-1:DATA_WIDTH]};
                end
                S_SEND: begin
                    if (cnt != '0 && cnt <= ADDR_LAST) cur_addr <= cur_addr >> EBI_WIDTH;
                    if (cnt >= DATA_FIRST)             line     <= line >> EBI_WIDTH;
                end
                S_WAIT: begin
                    if (start_beat) begin
                        if (ebi_i[3:0] != (cur_write ? OP_ACK : OP_RD_RESP)) err <= 1'b1;
                        if (beat_bad) par_err <= 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        err <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (cnt < RECV_MESI) line <= {ebi_i, line[CACHELINE_LENGTH-1:EBI_WIDTH]};
                    else                 rsp_mesi <= ebi_i[1:0];
                    if (beat_bad) par_err <= 1'b1;
                end
                S_RESP: begin
                    if (rready_i) line <= line >> DATA_WIDTH;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ebi_line_bridge.sv
// tb_ebi_line_bridge
//   Directed bench for ebi_line_bridge with default parameters. A table of
//   line transactions is driven through the pin protocol, plus hand-written
//   sequences for queue-full/timeout ordering and reset during SEND.
//   Build with EBI_PARITY_EN defined to include the parity port checks.
module tb_ebi_line_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_mesi_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [63:0] wdata_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [63:0] rdata_o;
    logic [1:0]  rmesi_o;
    logic        rlast_o;
    logic        rerr_o;
    logic [15:0] ebi_i;
    logic [15:0] ebi_o;
    logic [15:0] ebi_oen;
    logic        busy_o;
`ifdef EBI_PARITY_EN
    logic        ebi_par_o;
    logic        ebi_par_i;
    logic        par_flip = 1'b0;
    assign ebi_par_i = (^ebi_i) ^ par_flip;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    ebi_line_bridge dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_mesi_i(req_mesi_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
        .rmesi_o(rmesi_o), .rlast_o(rlast_o), .rerr_o(rerr_o),
        .ebi_i(ebi_i), .ebi_o(ebi_o), .ebi_oen(ebi_oen), .busy_o(busy_o)
`ifdef EBI_PARITY_EN
        , .ebi_par_o(ebi_par_o), .ebi_par_i(ebi_par_i)
`endif
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  mesi;
        logic [3:0]  rsp_op;
        logic [1:0]  rsp_mesi;
        logic [63:0] wbase;
        logic [15:0] rseed;
        int          stall_beat;
        int          par_flip_beat;
        int          exp_beats;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];
    int   nvec;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic wr, input logic [31:0] addr, input logic [1:0] mesi);
        int budget;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_mesi_i  = mesi;
        budget = 3000;
        while (!req_ready_o && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("push_wait", 64'd0, 64'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [511:0] wline, rline;
        logic [15:0]  sb[36];
        logic [63:0]  exp_data;
        int           nsb, budget, beat;
        logic         dw1, single;
        dw1    = v.write && (v.mesi == 2'b11);
        single = v.write || (v.rsp_op != 4'h7);
        for (int k = 0; k < 8; k++) wline[64*k +: 64] = v.wbase + 64'(k);
        for (int j = 0; j < 32; j++) rline[16*j +: 16] = v.rseed ^ 16'(j * 257);
        sb[0] = v.write ? (dw1 ? 16'h0001 : 16'h0002) : 16'h0000;
        sb[1] = v.addr[15:0];
        sb[2] = v.addr[31:16];
        sb[3] = {14'b0, v.mesi};
        nsb = 4;
        if (dw1) begin
            for (int j = 0; j < 32; j++) sb[4+j] = wline[16*j +: 16];
            nsb = 36;
        end

        ebi_i = 16'h0005;
        push_req(v.write, v.addr, v.mesi);
        if (dw1) begin
            for (int k = 0; k < 8; k++) begin
                wvalid_i = 1'b1;
                wdata_i  = wline[64*k +: 64];
                budget = 50;
                while (!wready_o && budget > 0) begin
                    tick();
                    budget--;
                end
                if (budget == 0) chk($sformatf("v%0d_wready_wait", idx), 64'd0, 64'd1);
                tick();
            end
            wvalid_i = 1'b0;
        end

        budget = 50;
        while (ebi_oen != 16'h0000 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk($sformatf("v%0d_send_start", idx), 64'd0, 64'd1);
        for (int i = 0; i < nsb; i++) begin
            chk($sformatf("v%0d_send%0d", idx, i), ebi_o, sb[i]);
`ifdef EBI_PARITY_EN
            chk($sformatf("v%0d_par%0d", idx, i), ebi_par_o, ^sb[i]);
`endif
            tick();
        end
        chk($sformatf("v%0d_turn_oen", idx), ebi_oen, 64'hFFFF);
        tick();

        ebi_i = {12'b0, v.rsp_op};
        tick();
        if (!single) begin
            for (int j = 0; j < 32; j++) begin
                ebi_i = rline[16*j +: 16];
`ifdef EBI_PARITY_EN
                par_flip = (j == v.par_flip_beat);
`endif
                tick();
            end
`ifdef EBI_PARITY_EN
            par_flip = 1'b0;
`endif
            ebi_i = {14'b0, v.rsp_mesi};
            tick();
        end
        ebi_i = 16'h0005;

        beat = 0;
        budget = 200;
        while (beat < v.exp_beats && budget > 0) begin
            if (rvalid_o) begin
                exp_data = single ? 64'd0 : rline[64*beat +: 64];
                chk($sformatf("v%0d_rdata%0d", idx, beat), rdata_o, exp_data);
                chk($sformatf("v%0d_rlast%0d", idx, beat), rlast_o, beat == v.exp_beats - 1);
                chk($sformatf("v%0d_rerr%0d", idx, beat), rerr_o, v.exp_err);
                if (!single) chk($sformatf("v%0d_rmesi%0d", idx, beat), rmesi_o, v.rsp_mesi);
                if (beat == v.stall_beat) begin
                    rready_i = 1'b0;
                    for (int s = 0; s < 10; s++) begin
                        tick();
                        chk($sformatf("v%0d_stall_rdata%0d", idx, s), rdata_o, exp_data);
                        chk($sformatf("v%0d_stall_rvalid%0d", idx, s), rvalid_o, 1'b1);
                    end
                    rready_i = 1'b1;
                end
                tick();
                beat++;
            end else begin
                tick();
                budget--;
            end
        end
        if (beat < v.exp_beats) chk($sformatf("v%0d_resp_count", idx), beat, v.exp_beats);
        chk($sformatf("v%0d_no_extra_beat", idx), rvalid_o, 1'b0);
        chk($sformatf("v%0d_idle_busy", idx), busy_o, 1'b0);
    endtask

    task automatic timeout_seq();
        int budget, last_t;
        ebi_i = 16'h0005;
        for (int i = 0; i < 5; i++) push_req(1'b0, 32'h1000_0000 + 32'(i * 64), 2'b00);
        chk("q_full_ready", req_ready_o, 1'b0);
        chk("q_full_busy", busy_o, 1'b1);
        last_t = 0;
        for (int r = 0; r < 5; r++) begin
            budget = 1500;
            while (!rvalid_o && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) chk($sformatf("to%0d_wait", r), 64'd0, 64'd1);
            chk($sformatf("to%0d_rerr", r), rerr_o, 1'b1);
            chk($sformatf("to%0d_rlast", r), rlast_o, 1'b1);
            chk($sformatf("to%0d_rdata", r), rdata_o, 64'd0);
            if (r > 0) chk($sformatf("to%0d_interval", r), 64'(cyc - last_t), 64'd1031);
            if (r == 1) chk("to_ready_back", req_ready_o, 1'b1);
            last_t = cyc;
            tick();
        end
        chk("to_done_busy", busy_o, 1'b0);
    endtask

    task automatic reset_seq();
        int budget;
        ebi_i = 16'h0005;
        push_req(1'b0, 32'hAAAA_0040, 2'b01);
        push_req(1'b0, 32'hBBBB_0080, 2'b00);
        budget = 50;
        while (ebi_oen != 16'h0000 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("rst_send_start", 64'd0, 64'd1);
        tick();
        chk("rst_mid_send_oen", ebi_oen, 64'h0000);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_oen", ebi_oen, 64'hFFFF);
        chk("rst_async_ebi_o", ebi_o, 64'd0);
        chk("rst_async_busy", busy_o, 1'b0);
        chk("rst_async_ready", req_ready_o, 1'b1);
        chk("rst_async_rvalid", rvalid_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_after_oen", ebi_oen, 64'hFFFF);
        chk("rst_after_busy", busy_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_mesi_i  = '0;
        wvalid_i    = 1'b0;
        wdata_i     = '0;
        rready_i    = 1'b1;
        ebi_i       = 16'h0005;
        #3;
        chk("reset_req_ready", req_ready_o, 1'b1);
        chk("reset_wready", wready_o, 1'b0);
        chk("reset_rvalid", rvalid_o, 1'b0);
        chk("reset_rlast", rlast_o, 1'b0);
        chk("reset_rerr", rerr_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_rmesi", rmesi_o, 2'd0);
        chk("reset_ebi_o", ebi_o, 64'd0);
        chk("reset_ebi_oen", ebi_oen, 64'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        //                 wr    addr           mesi   rsp    rmesi  wbase                     rseed     stall par beats err
        vecs[0] = '{1'b0, 32'h8000_0040, 2'd0, 4'h7, 2'd2, 64'd0,                   16'h5A00, -1,  -1,  8, 1'b0};
        vecs[1] = '{1'b1, 32'h1234_5680, 2'd3, 4'hF, 2'd0, 64'd0,                   16'h0000, -1,  -1,  1, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_ABC0, 2'd1, 4'hF, 2'd0, 64'd0,                   16'h0000, -1,  -1,  1, 1'b0};
        vecs[3] = '{1'b0, 32'hDEAD_BEC0, 2'd0, 4'hF, 2'd0, 64'd0,                   16'h0000, -1,  -1,  1, 1'b1};
        vecs[4] = '{1'b0, 32'h0F0F_0100, 2'd2, 4'h7, 2'd1, 64'd0,                   16'hC3A5,  3,  -1,  8, 1'b0};
        vecs[5] = '{1'b1, 32'h7654_3210, 2'd3, 4'h7, 2'd0, 64'h0123_4567_89AB_0000, 16'h0000, -1,  -1,  1, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_0000, 2'd0, 4'h2, 2'd0, 64'd0,                   16'h0000, -1,  -1,  1, 1'b1};
        nvec = 7;
`ifdef EBI_PARITY_EN
        vecs[7] = '{1'b0, 32'h4000_0080, 2'd0, 4'h7, 2'd3, 64'd0,                   16'h0F0F, -1,   2,  8, 1'b1};
        nvec = 8;
`endif

        for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);
        timeout_seq();
        reset_seq();
        run_vec(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
